// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one byte-wide unified RAM port between instruction fetch (IF)
//   and load/store (MEM). Multi-byte transfers are serialised one byte per
//   cycle. MEM has priority; transfers are non-preemptive except that an IF
//   fetch is abandoned on if_flush_i.
//
// Ports
//   clk_in, rst_n_in          clock, synchronous active-low reset
//   if_req_i/if_addr_i        IF word fetch request (held until if_done_o)
//   if_flush_i                abort pending or in-flight IF fetch
//   if_done_o/if_data_o       one-cycle done pulse, little-endian word
//   if_stall_req_o            IF request outstanding (combinational)
//   mem_req_i/we/size/addr/wdata  MEM request (held until mem_done_o)
//   mem_done_o/mem_rdata_o    one-cycle done pulse, zero-extended load data
//   mem_stall_req_o           MEM request outstanding (combinational)
//   ram_din/ram_dout/ram_a/ram_wr  byte RAM port; read data lags address by one cycle
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  input  logic                  if_flush_i,
  output logic                  if_done_o,
  output logic [31:0]           if_data_o,
  output logic                  if_stall_req_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_size_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  output logic                  mem_done_o,
  output logic [31:0]           mem_rdata_o,
  output logic                  mem_stall_req_o,
  input  logic [7:0]            ram_din,
  output logic [7:0]            ram_dout,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_wr
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t                r_state;
  logic                  r_is_mem;   // owner of the current transfer
  logic [2:0]            r_n;        // byte count: 1, 2 or 4
  logic [2:0]            r_cnt;      // edges elapsed since acceptance
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_buf;      // read assembly buffer, cleared on accept

  logic [ADDR_WIDTH-1:0] r_ram_a;
  logic [7:0]            r_ram_dout;
  logic                  r_ram_wr;
  logic                  r_if_done;
  logic                  r_mem_done;
  logic [31:0]           r_if_data;
  logic [31:0]           r_mem_rdata;

  logic                  w_mem_go;
  logic                  w_if_go;
  logic [2:0]            w_mem_n;
  logic [1:0]            w_lane;
  logic [31:0]           w_buf_nxt;
  logic [ADDR_WIDTH-1:0] w_byte_addr;
  logic [7:0]            w_wbyte;

  // A port whose done is high this cycle is locked out at this edge so a
  // still-held request is not re-accepted before the requester sees done.
  assign w_mem_go = mem_req_i & ~r_mem_done;
  assign w_if_go  = if_req_i & ~if_flush_i & ~r_if_done;

  always_comb begin
    w_mem_n = 3'd4;
    if (mem_size_i == 2'b00)      w_mem_n = 3'd1;
    else if (mem_size_i == 2'b01) w_mem_n = 3'd2;
  end

  // Byte issued at edge E0+k arrives on ram_din in time for edge E0+k+2.
  assign w_lane      = 2'(r_cnt - 3'd2);
  assign w_byte_addr = r_addr + ADDR_WIDTH'(r_cnt);
  assign w_wbyte     = r_wdata[{r_cnt[1:0], 3'b000} +: 8];

  always_comb begin
    w_buf_nxt = r_buf;
    w_buf_nxt[{w_lane, 3'b000} +: 8] = ram_din;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state     <= S_IDLE;
      r_is_mem    <= 1'b0;
      r_n         <= 3'd0;
      r_cnt       <= 3'd0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_ram_a     <= '0;
      r_ram_dout  <= '0;
      r_ram_wr    <= 1'b0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ram_wr <= 1'b0;
          if (w_mem_go) begin
            r_is_mem <= 1'b1;
            r_n      <= w_mem_n;
            r_addr   <= mem_addr_i;
            r_wdata  <= mem_wdata_i;
            r_buf    <= '0;
            r_cnt    <= 3'd1;
            r_ram_a  <= mem_addr_i;
            if (mem_we_i) begin
              r_ram_dout <= mem_wdata_i[7:0];
              r_ram_wr   <= 1'b1;
              r_state    <= S_WRITE;
            end else begin
              r_state    <= S_READ;
            end
          end else if (w_if_go) begin
            r_is_mem <= 1'b0;
            r_n      <= 3'd4;
            r_addr   <= if_addr_i;
            r_buf    <= '0;
            r_cnt    <= 3'd1;
            r_ram_a  <= if_addr_i;
            r_state  <= S_READ;
          end
        end
        S_READ: begin
          if (!r_is_mem && if_flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt < r_n)   r_ram_a <= w_byte_addr;
            if (r_cnt >= 3'd2) r_buf   <= w_buf_nxt;
            if (r_cnt == r_n + 3'd1) begin
              // last byte comes straight from ram_din into the output
              if (r_is_mem) begin
                r_mem_done  <= 1'b1;
                r_mem_rdata <= w_buf_nxt;
              end else begin
                r_if_done   <= 1'b1;
                r_if_data   <= w_buf_nxt;
              end
              r_state <= S_IDLE;
            end
          end
        end
        S_WRITE: begin
          if (r_cnt < r_n) begin
            r_ram_a    <= w_byte_addr;
            r_ram_dout <= w_wbyte;
            r_ram_wr   <= 1'b1;
            r_cnt      <= r_cnt + 3'd1;
          end else begin
            r_ram_wr   <= 1'b0;
            r_mem_done <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ram_a       = r_ram_a;
  assign ram_dout    = r_ram_dout;
  assign ram_wr      = r_ram_wr;
  assign if_done_o   = r_if_done;
  assign if_data_o   = r_if_data;
  assign mem_done_o  = r_mem_done;
  assign mem_rdata_o = r_mem_rdata;

  assign if_stall_req_o  = if_req_i & ~r_if_done & ~if_flush_i;
  assign mem_stall_req_o = mem_req_i & ~r_mem_done;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide unified RAM port between instruction fetch (IF) and load/store (MEM).
- Serialises multi-byte transfers into one byte per cycle.
- Raises if_stall_req_o and mem_stall_req_o to the stall bus while a port's request is outstanding.
- MEM has priority over IF. Transfers are non-preemptive, except that an IF fetch can be aborted by a flush.

Parameters:
ADDR_WIDTH, 32, width of all addresses and the RAM address bus

Ports:
clk_in  input  1  clock
rst_n_in  input  1  synchronous active-low reset
if_req_i  input  1  IF word-fetch request; held high with stable if_addr_i until if_done_o
if_addr_i  input  ADDR_WIDTH  IF fetch address
if_flush_i  input  1  abort any pending or in-flight IF fetch
if_done_o  output  1  one-cycle pulse; if_data_o valid
if_data_o  output  32  fetched word, little-endian
if_stall_req_o  output  1  IF request outstanding
mem_req_i  input  1  MEM request; held high with stable inputs until mem_done_o
mem_we_i  input  1  1 = store, 0 = load
mem_size_i  input  2  00 = byte, 01 = half, 10 or 11 = word
mem_addr_i  input  ADDR_WIDTH  MEM address
mem_wdata_i  input  32  store data (low bytes used)
mem_done_o  output  1  one-cycle pulse; load data valid or store complete
mem_rdata_o  output  32  load data, zero-extended
mem_stall_req_o  output  1  MEM request outstanding
ram_din  input  8  RAM read data
ram_dout  output  8  RAM write data
ram_a  output  ADDR_WIDTH  RAM byte address
ram_wr  output  1  RAM write strobe

Behaviour:
- RAM model:
  - ram_din in cycle t equals RAM[ram_a in cycle t-1].
  - A write happens at the edge that ends a cycle in which ram_wr = 1.
- Registered outputs: ram_a, ram_dout, ram_wr, both done pulses, both data outputs.
- Combinational outputs:
  - if_stall_req_o = if_req_i & ~if_done_o & ~if_flush_i
  - mem_stall_req_o = mem_req_i & ~mem_done_o
- Reset (rst_n_in low at an edge):
  - state IDLE; all registered outputs 0.
  - Any in-flight transfer is aborted with no done pulse, and ram_wr is 0 from that edge on.
- FSM states:
  - IDLE: evaluates requests each edge.
    - If mem_req_i is high: latch address, size, data and we.
    - Else if if_req_i is high and if_flush_i is low: latch the IF address.
    - Go to READ or WRITE. N = byte count (1, 2 or 4; IF is always 4).
  - In IDLE, ram_wr = 0 and ram_a, ram_dout hold their last values.
  - Lockout: a port whose done is high in the current cycle is not accepted at that edge; the other port may be.
  - READ:
    - Address A+k is issued at acceptance edge E0+k, for k = 0..N-1.
    - Byte k is captured from ram_din at edge E0+k+2 into byte lane k.
    - At edge E0+N+1: done and data are registered and the FSM returns to IDLE.
    - The done pulse is therefore high N+1 cycles after acceptance: word read 5, byte read 2.
  - WRITE:
    - At edge E0+k: ram_a = A+k, ram_dout = wdata byte k, ram_wr = 1.
    - At edge E0+N: ram_wr is cleared, mem_done_o is set and the FSM returns to IDLE (word store: 4 cycles).
- Address arithmetic: A+k wraps modulo 2^ADDR_WIDTH. No alignment checks.
- Latched inputs: changes to requester inputs during a transfer are ignored.
- Unused upper lanes of mem_rdata_o are 0.
- Flush:
  - if_flush_i high during an IF READ returns the FSM to IDLE at that edge, with no if_done_o.
  - A MEM request pending at that edge is accepted at the next edge.
  - A flush has no effect on a MEM transfer.
- Done pulses last exactly one cycle. if_data_o and mem_rdata_o hold their value until the next done for that port.
- Simultaneous requests in IDLE: MEM wins. IF waits with if_stall_req_o high.

Test Plan:
- Reset, then IF fetch at 0x0000_0010 with RAM[0x10..0x13] = 11 22 33 44 -> ram_a steps 0x10..0x13 on 4 consecutive cycles; if_done_o pulses 5 cycles after acceptance; if_data_o = 0x44332211; if_stall_req_o high until the done cycle.
- Word store of 0xDEADBEEF to 0x100 -> ram_wr high 4 cycles; bytes EF BE AD DE at 0x100..0x103; mem_done_o 4 cycles after acceptance; ram_wr low in the done cycle.
- if_req_i and mem_req_i (byte load at 0x20, RAM[0x20] = 0x80) rise together -> MEM served first; mem_rdata_o = 0x00000080 after 2 cycles; IF accepted at the edge after mem_done_o; if_stall_req_o high throughout.
- IF fetch, if_flush_i pulsed in the 2nd READ cycle with mem_req_i high -> no if_done_o; MEM load accepted at the next edge and completes normally.
- Back-to-back IF with if_req_i held high across if_done_o -> no re-acceptance in the done cycle; the second fetch starts the following edge at the new address.
- rst_n_in low during the 2nd cycle of a word store -> ram_wr 0 from the reset edge; only byte 0 written; no mem_done_o; all outputs 0.
